// File: rtl/heat_sensor_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for the
// multi-channel ring-oscillator heat sensor.
package heat_sensor_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_WINDOW = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_THRESH = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_COUNT0 = 4'd4;

  localparam int unsigned CTRL_RUN_BIT     = 0;
  localparam int unsigned CTRL_MASK_LSB    = 8;
  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_VALID_LSB = 8;
  localparam int unsigned STATUS_ALARM_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LATCH   = 2'd2
  } state_e;

  // Word address of COUNT[i].
  function automatic logic [ADDR_W-1:0] count_addr(input int unsigned i);
    return ADDR_COUNT0 + ADDR_W'(i);
  endfunction

endpackage

// File: rtl/multi_heat_sensor_if.sv
// Avalon-MM style register slave bus for the heat sensor.
interface multi_heat_sensor_if;
  import heat_sensor_pkg::*;

  logic [ADDR_W-1:0] avs_s0_address;
  logic              avs_s0_read;
  logic              avs_s0_write;
  logic [DATA_W-1:0] avs_s0_writedata;
  logic [DATA_W-1:0] avs_s0_readdata;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata
  );
endinterface

// File: rtl/heat_sensor_channel.sv
// One sensor channel: synchroniser for the async oscillator tap, rising-edge
// detect and a saturating edge counter.
module heat_sensor_channel #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             osc,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Clear has priority; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && rise_c && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_heat_sensor.sv
// Multi-channel heat sensor: per-channel oscillator edge counters gated by a
// programmable measurement window, with results and alarms in a register file.
module multi_heat_sensor
  import heat_sensor_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned WIN_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_heat_sensor_if.slave   bus,
  input  logic [N_CH-1:0]      osc_in,
  output logic [N_CH-1:0]      heat_en,
  output logic [N_CH-1:0]      alarm
);

  state_e            state_q, state_d;
  logic              start_c;
  logic              latch_c;
  logic              count_en_c;

  logic              ctrl_run_q;
  logic [WIN_W-1:0]  window_q;
  logic [CNT_W-1:0]  thresh_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [WIN_W-1:0]  win_last_q;

  logic [CNT_W-1:0]  cnt     [N_CH];
  logic [CNT_W-1:0]  count_q [N_CH];
  logic [N_CH-1:0]   valid_q;
  logic [N_CH-1:0]   alarm_c;
  logic [N_CH-1:0]   rd_clr_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              unused_wdata_c;

  assign unused_wdata_c = ^bus.avs_s0_writedata;
  assign count_en_c     = (state_q == ST_MEASURE);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    heat_sensor_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .osc      (osc_in[i]),
      .clear    (start_c),
      .count_en (count_en_c),
      .count    (cnt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; start_c opens a window (counters cleared), latch_c commits results.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    latch_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_run_q) begin
          state_d = ST_MEASURE;
          start_c = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!ctrl_run_q)                     state_d = ST_IDLE;
        else if (win_cnt_q == win_last_q)    state_d = ST_LATCH;
      end
      ST_LATCH: begin
        latch_c = 1'b1;
        if (ctrl_run_q) begin
          state_d = ST_MEASURE;
          start_c = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window length is sampled at window start so mid-window writes apply next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q  <= '0;
      win_last_q <= '0;
    end else if (start_c) begin
      win_cnt_q  <= '0;
      win_last_q <= (window_q == '0) ? '0 : window_q - WIN_W'(1);
    end else if (state_q == ST_MEASURE) begin
      win_cnt_q  <= win_cnt_q + WIN_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      alarm_c[i]  = (cnt[i] < thresh_q);
      rd_clr_c[i] = bus.avs_s0_read && (bus.avs_s0_address == count_addr(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_run_q <= 1'b0;
      heat_en    <= '0;
      window_q   <= '0;
      thresh_q   <= '0;
    end else if (bus.avs_s0_write) begin
      case (bus.avs_s0_address)
        ADDR_CTRL: begin
          ctrl_run_q <= bus.avs_s0_writedata[CTRL_RUN_BIT];
          heat_en    <= bus.avs_s0_writedata[CTRL_MASK_LSB +: N_CH];
        end
        ADDR_WINDOW: window_q <= bus.avs_s0_writedata[WIN_W-1:0];
        ADDR_THRESH: thresh_q <= bus.avs_s0_writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Results; a LATCH setting valid wins over a same-cycle COUNT read clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      alarm   <= '0;
      for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
    end else if (latch_c) begin
      valid_q <= '1;
      alarm   <= alarm_c;
      for (int i = 0; i < N_CH; i++) count_q[i] <= cnt[i];
    end else begin
      valid_q <= valid_q & ~rd_clr_c;
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (bus.avs_s0_address)
      ADDR_CTRL:   rd_data_c = DATA_W'(ctrl_run_q) |
                               (DATA_W'(heat_en) << CTRL_MASK_LSB);
      ADDR_WINDOW: rd_data_c = DATA_W'(window_q);
      ADDR_THRESH: rd_data_c = DATA_W'(thresh_q);
      ADDR_STATUS: rd_data_c = (DATA_W'(state_q != ST_IDLE) << STATUS_BUSY_BIT) |
                               (DATA_W'(valid_q) << STATUS_VALID_LSB) |
                               (DATA_W'(alarm)   << STATUS_ALARM_LSB);
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          if (bus.avs_s0_address == count_addr(i)) rd_data_c = DATA_W'(count_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                 bus.avs_s0_readdata <= '0;
    else if (bus.avs_s0_read)  bus.avs_s0_readdata <= rd_data_c;
  end

endmodule

// File: tb/tb_multi_heat_sensor.sv
// Bench for multi_heat_sensor: register table, windowed counting, saturation
// (8-bit counter instance), run abort, LATCH/read race and reset abort.
module tb_multi_heat_sensor;
  import heat_sensor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        rd_s, wr_s, chk_s, sel;
  logic [31:0] wdata, rdata;
  logic [3:0]  osc0, osc1, heat0, heat1, alarm0, alarm1;
  int          per0, per1, ph;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_heat;
  } vec_t;
  vec_t vecs[9];

  multi_heat_sensor_if bus0 ();
  multi_heat_sensor_if bus1 ();

  assign bus0.avs_s0_address   = addr;
  assign bus0.avs_s0_read      = rd_s & ~sel;
  assign bus0.avs_s0_write     = wr_s & ~sel;
  assign bus0.avs_s0_writedata = wdata;
  assign bus1.avs_s0_address   = addr;
  assign bus1.avs_s0_read      = rd_s & sel;
  assign bus1.avs_s0_write     = wr_s & sel;
  assign bus1.avs_s0_writedata = wdata;
  assign rdata = sel ? bus1.avs_s0_readdata : bus0.avs_s0_readdata;

  multi_heat_sensor dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave),
    .osc_in(osc0), .heat_en(heat0), .alarm(alarm0)
  );

  multi_heat_sensor #(.CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .osc_in(osc1), .heat_en(heat1), .alarm(alarm1)
  );

  always #5 clk = ~clk;

  // Oscillator taps on channel 0 of each instance, 50% duty, period in clocks.
  initial begin
    osc0 = '0; osc1 = '0; ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      osc0 = {3'b000, (per0 != 0) && ((ph % per0) < (per0 / 2))};
      osc1 = {3'b000, (per1 != 0) && ((ph % per1) < (per1 / 2))};
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] lo, input logic [31:0] hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h..0x%08h", name, act, lo, hi);
    end
  endtask

  // Scoreboard: a checked read one cycle earlier has its result on rdata now.
  logic chk_seen = 1'b0;
  always @(posedge clk) chk_seen <= rd_s & chk_s;
  initial forever begin
    @(negedge clk);
    if (chk_seen) begin
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, rdata, e.lo, e.hi);
      end
    end
  end

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_s = 1'b1;
    @(negedge clk);
    wr_s = 1'b0;
  endtask

  task automatic bus_rd_raw(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd_s = 1'b1; chk_s = 1'b0;
    @(negedge clk);
    rd_s = 1'b0;
    d = rdata;
  endtask

  task automatic bus_rd(input logic [3:0] a, input string name,
                        input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    e.name = name; e.lo = lo; e.hi = hi;
    sb_q.push_back(e);
    @(negedge clk);
    addr = a; rd_s = 1'b1; chk_s = 1'b1;
    @(negedge clk);
    rd_s = 1'b0; chk_s = 1'b0;
  endtask

  task automatic wait_valid(input logic [3:0] mask, input int limit, input string name);
    logic [31:0] d;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      bus_rd_raw(ADDR_STATUS, d);
      if ((d[STATUS_VALID_LSB +: 4] & mask) == mask) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1, 32'd1);
  endtask

  initial begin
    addr = '0; wdata = '0; rd_s = 0; wr_s = 0; chk_s = 0; sel = 0;
    per0 = 0; per1 = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state: every address reads 0, outputs low.
    check("rst_heat0",  32'(heat0),  32'd0, 32'd0);
    check("rst_alarm0", 32'(alarm0), 32'd0, 32'd0);
    check("rst_heat1",  32'(heat1),  32'd0, 32'd0);
    for (int a = 0; a < 16; a++) bus_rd(4'(a), $sformatf("rst_rd_%0d", a), 32'd0, 32'd0);

    bus_wr(ADDR_CTRL, 32'h300);
    check("heat_mask_3", 32'(heat0), 32'h3, 32'h3);
    bus_wr(ADDR_CTRL, 32'h0);
    check("heat_mask_0", 32'(heat0), 32'h0, 32'h0);

    vecs[0] = '{ADDR_CTRL,   32'h0000_0F00, 32'h0000_0F00, 4'hF};
    vecs[1] = '{ADDR_CTRL,   32'hFFFF_FFFE, 32'h0000_0F00, 4'hF};
    vecs[2] = '{ADDR_CTRL,   32'h0000_0500, 32'h0000_0500, 4'h5};
    vecs[3] = '{ADDR_WINDOW, 32'hFFFF_FFFF, 32'h00FF_FFFF, 4'h5};
    vecs[4] = '{ADDR_THRESH, 32'hABCD_1234, 32'h00CD_1234, 4'h5};
    vecs[5] = '{ADDR_STATUS, 32'hFFFF_FFFF, 32'h0000_0000, 4'h5};
    vecs[6] = '{ADDR_COUNT0, 32'hFFFF_FFFF, 32'h0000_0000, 4'h5};
    vecs[7] = '{4'd9,        32'h1234_5678, 32'h0000_0000, 4'h5};
    vecs[8] = '{4'd15,       32'h1234_5678, 32'h0000_0000, 4'h5};
    for (int i = 0; i < 9; i++) begin
      bus_wr(vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_heat", i), 32'(heat0), 32'(vecs[i].exp_heat), 32'(vecs[i].exp_heat));
      bus_rd(vecs[i].addr, $sformatf("vec%0d_rd", i), vecs[i].exp_rd, vecs[i].exp_rd);
    end
    bus_wr(ADDR_CTRL, 32'h0);

    // 40-cycle window, channel 0 period 4: about 10 edges, other channels alarm.
    per0 = 4;
    bus_wr(ADDR_WINDOW, 32'd40);
    bus_wr(ADDR_THRESH, 32'd5);
    bus_wr(ADDR_CTRL, 32'h1);
    wait_valid(4'hF, 100, "win40_valid_timeout");
    bus_wr(ADDR_CTRL, 32'h0);
    bus_rd(ADDR_STATUS, "win40_status", 32'h000E_0F00, 32'h000E_0F00);
    check("win40_alarm_port", 32'(alarm0), 32'hE, 32'hE);
    bus_rd(ADDR_COUNT0,     "win40_count0", 32'd9, 32'd11);
    bus_rd(count_addr(1),   "win40_count1", 32'd0, 32'd0);
    bus_rd(count_addr(2),   "win40_count2", 32'd0, 32'd0);
    bus_rd(count_addr(3),   "win40_count3", 32'd0, 32'd0);
    bus_rd(ADDR_STATUS, "win40_status_rdclr", 32'h000E_0000, 32'h000E_0000);

    // Run dropped mid-window: idle, nothing committed.
    bus_wr(ADDR_THRESH, 32'd50);
    bus_wr(ADDR_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    bus_wr(ADDR_CTRL, 32'h0);
    bus_rd(ADDR_STATUS, "abort_status", 32'h000E_0000, 32'h000E_0000);
    bus_rd(ADDR_COUNT0, "abort_count0", 32'd9, 32'd11);

    // COUNT[0] read lands exactly on the LATCH cycle: set wins.
    bus_wr(ADDR_WINDOW, 32'd10);
    bus_wr(ADDR_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    bus_rd(ADDR_COUNT0, "race_count_old", 32'd9, 32'd11);
    bus_rd(ADDR_STATUS, "race_status_set", 32'h000F_0F01, 32'h000F_0F01);
    bus_rd(ADDR_COUNT0, "race_count_new", 32'd2, 32'd3);
    bus_rd(ADDR_STATUS, "race_status_clr", 32'h000F_0E01, 32'h000F_0E01);
    bus_wr(ADDR_CTRL, 32'h0);

    // WINDOW=0 behaves as a 1-cycle window.
    bus_wr(ADDR_WINDOW, 32'd0);
    bus_wr(ADDR_CTRL, 32'h1);
    wait_valid(4'h1, 20, "win0_valid_timeout");
    bus_wr(ADDR_CTRL, 32'h0);
    bus_rd(ADDR_COUNT0, "win0_count0", 32'd0, 32'd1);
    check("win0_alarm_port", 32'(alarm0), 32'hF, 32'hF);

    // 8-bit counter instance: ~500 edges must saturate at 255.
    sel = 1'b1;
    per1 = 2;
    bus_wr(ADDR_WINDOW, 32'd1000);
    bus_wr(ADDR_CTRL, 32'h1);
    wait_valid(4'h1, 700, "sat_valid_timeout");
    bus_wr(ADDR_CTRL, 32'h0);
    bus_rd(ADDR_COUNT0,   "sat_count0", 32'd255, 32'd255);
    bus_rd(count_addr(1), "sat_count1", 32'd0, 32'd0);
    bus_rd(ADDR_STATUS,   "sat_status", 32'h0000_0C00, 32'h0000_0C00);
    check("sat_alarm_port", 32'(alarm1), 32'h0, 32'h0);
    sel = 1'b0;

    // Reset in the middle of a window clears everything.
    bus_wr(ADDR_CTRL, 32'h0F01);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_heat", 32'(heat0), 32'h0, 32'h0);
    check("rst_mid_alarm", 32'(alarm0), 32'h0, 32'h0);
    bus_rd(ADDR_STATUS, "rst_mid_status", 32'h0, 32'h0);
    bus_rd(ADDR_COUNT0, "rst_mid_count0", 32'h0, 32'h0);
    bus_rd(ADDR_CTRL,   "rst_mid_ctrl",   32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1);
  end

endmodule
